iomem_timer: RTL

Memory-mapped 32-bit down-counting timer with prescaler and interrupt output. It sits on the picosoc `iomem` peripheral bus and is enabled by the top-level decode `iomem_addr[31:24] == 8'h0A`. It answers with its own `iomem_ready`/`iomem_rdata` into the top-level ready/rdata mux. Its `irq` output drives the SoC `irq_5` input, which is currently tied to zero.

---
 rtl/iomem_timer_pkg.sv | 28 ++
 rtl/timer_prescaler.sv | 37 +++
 rtl/iomem_timer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/iomem_timer_pkg.sv
// Shared constants and helpers for the iomem timer peripheral.
package iomem_timer_pkg;

    // Register byte offsets, compared against {iomem_addr[4:2], 2'b00}
    localparam logic [4:0] TIMER_CTRL     = 5'h00;
    localparam logic [4:0] TIMER_PRESCALE = 5'h04;
    localparam logic [4:0] TIMER_COUNT    = 5'h08;
    localparam logic [4:0] TIMER_RELOAD   = 5'h0C;
    localparam logic [4:0] TIMER_STATUS   = 5'h10;

    // CTRL bit positions
    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_AUTO  = 1;
    localparam int unsigned CTRL_IRQEN = 2;

    // Merge write data into an existing word, one byte per strobe bit
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: emits a one-cycle tick every divisor+1 cycles while enabled.
module timer_prescaler #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic [WIDTH-1:0] divisor,
    output logic             tick
);

    logic [WIDTH-1:0] pcnt_q, pcnt_d;

    // Tick when the running count meets the divisor; a divisor lowered below pcnt
    // is only met after pcnt wraps through its full width.
    always_comb begin
        tick   = en && (pcnt_q == divisor);
        pcnt_d = pcnt_q;
        if (!en) begin
            pcnt_d = '0;
        end else if (tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + WIDTH'(1);
        end
    end

    // Prescaler count register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/iomem_timer.sv
// Memory-mapped 32-bit down-counting timer with prescaler and level interrupt.
module iomem_timer
    import iomem_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        iomem_ready,
    output logic        irq
);

    logic                      ready_q;
    logic [31:0]               rdata_q, rdata_d;
    logic [2:0]                ctrl_q, ctrl_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [31:0]               count_q, count_d;
    logic [31:0]               reload_q, reload_d;
    logic                      expired_q, expired_d;
    logic                      irq_q;
    logic                      tick;

    logic        access;
    logic        wr;
    logic [4:0]  offset;
    logic        expire;
    logic [31:0] read_val;
    logic        unused_addr;

    assign unused_addr = ^{iomem_addr[31:5], iomem_addr[1:0]};

    // One wait state: accept only when ready is not already being returned
    assign access = iomem_valid && !ready_q;
    assign wr     = access && (iomem_wstrb != 4'b0000);
    assign offset = {iomem_addr[4:2], 2'b00};
    assign expire = tick && (count_q == 32'd0);

    timer_prescaler #(
        .WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk    (clk),
        .resetn (resetn),
        .en     (ctrl_q[CTRL_EN]),
        .divisor(prescale_q),
        .tick   (tick)
    );

    // Readback mux; COUNT returns the value held before this edge
    always_comb begin
        read_val = 32'd0;
        case (offset)
            TIMER_CTRL:     read_val = {29'd0, ctrl_q};
            TIMER_PRESCALE: read_val = 32'(prescale_q);
            TIMER_COUNT:    read_val = count_q;
            TIMER_RELOAD:   read_val = reload_q;
            TIMER_STATUS:   read_val = {31'd0, expired_q};
            default:        read_val = 32'd0;
        endcase
        rdata_d = access ? read_val : rdata_q;
    end

    // Register next-state: bus writes beat tick-side updates, except STATUS clear
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        count_d    = count_q;
        reload_d   = reload_q;
        expired_d  = expired_q;

        if (expire && !ctrl_q[CTRL_AUTO]) ctrl_d[CTRL_EN] = 1'b0;
        if (wr && offset == TIMER_CTRL && iomem_wstrb[0]) ctrl_d = iomem_wdata[2:0];

        if (wr && offset == TIMER_PRESCALE) begin
            prescale_d = PRESCALE_WIDTH'(apply_wstrb(32'(prescale_q), iomem_wdata,
                                                     iomem_wstrb));
        end

        if (wr && offset == TIMER_COUNT) begin
            count_d = apply_wstrb(count_q, iomem_wdata, iomem_wstrb);
        end else if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (ctrl_q[CTRL_AUTO]) begin
                count_d = reload_q;
            end
        end

        if (wr && offset == TIMER_RELOAD) begin
            reload_d = apply_wstrb(reload_q, iomem_wdata, iomem_wstrb);
        end

        if (expire) begin
            expired_d = 1'b1;
        end else if (wr && offset == TIMER_STATUS && iomem_wstrb[0] && iomem_wdata[0]) begin
            expired_d = 1'b0;
        end
    end

    // State registers, bus handshake and registered interrupt
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q    <= 1'b0;
            rdata_q    <= 32'd0;
            ctrl_q     <= 3'd0;
            prescale_q <= '0;
            count_q    <= 32'd0;
            reload_q   <= 32'd0;
            expired_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ready_q    <= access;
            rdata_q    <= rdata_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            expired_q  <= expired_d;
            irq_q      <= expired_q && ctrl_q[CTRL_IRQEN];
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign irq         = irq_q;

endmodule
